// File: rtl/wimax_pkg.sv
// Shared WiMAX transmit-chain definitions.
//   NCBPS / NCPC       : coded bits per OFDM block / per carrier (QPSK)
//   IQ_W               : signed I/Q sample width (Q1.15)
//   QPSK_AMP_POS/NEG   : +/- 1/sqrt(2) in Q1.15
//   iq_sample_t        : packed I/Q pair
package wimax_pkg;

  localparam int unsigned NCBPS = 192;
  localparam int unsigned NCPC  = 2;
  localparam int unsigned IQ_W  = 16;

  localparam logic signed [IQ_W-1:0] QPSK_AMP_POS = 16'sh5A82;
  localparam logic signed [IQ_W-1:0] QPSK_AMP_NEG = 16'shA57E;

  typedef struct packed {
    logic signed [IQ_W-1:0] i;
    logic signed [IQ_W-1:0] q;
  } iq_sample_t;

endpackage

// File: rtl/pingpong_bit_buffer.sv
// Two DEPTH-bit storage banks for one block each.
//   clk      : system clock
//   wr_en    : write strobe (address already range-checked by the parent)
//   wr_bank  : bank receiving the write
//   wr_addr  : bit position within the bank
//   wr_data  : bit value
//   rd_bank  : bank being read
//   rd_pair  : bit-pair index; returns bits 2*rd_pair and 2*rd_pair+1
//   rd_bits  : {bit 2*rd_pair+1, bit 2*rd_pair}
// Contents are not reset; full/pointer bookkeeping lives in the parent.
module pingpong_bit_buffer #(
  parameter int unsigned DEPTH = 192,
  parameter int unsigned AW    = 8,
  parameter int unsigned PW    = 7
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  input  logic          rd_bank,
  input  logic [PW-1:0] rd_pair,
  output logic [1:0]    rd_bits
);

  logic [DEPTH-1:0] mem [2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  assign rd_bits = {mem[rd_bank][{rd_pair, 1'b1}], mem[rd_bank][{rd_pair, 1'b0}]};

endmodule

// File: rtl/qpsk_mapper_buffer.sv
// Ping-pong de-interleave buffer plus QPSK (Gray) mapper.
//   clk, reset          : clock, synchronous active-high reset
//   valid_interleaver   : data_in/data_in_index valid
//   data_in             : interleaved bit
//   data_in_index       : destination bit position within the block
//   ready_buffer        : current write bank can accept a bit
//   ready_in            : downstream accepts the presented symbol
//   valid_out           : i_out/q_out/symbol_index/last_symbol valid
//   i_out, q_out        : signed Q1.15 symbol components
//   symbol_index        : subcarrier index 0..Ncbps/Ncpc-1
//   last_symbol         : final symbol of a block
module qpsk_mapper_buffer
  import wimax_pkg::*;
#(
  parameter int unsigned Ncbps = NCBPS,
  parameter int unsigned Ncpc  = NCPC,
  parameter int unsigned W     = IQ_W,
  parameter int unsigned AMP   = 23170
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              valid_interleaver,
  input  logic                              data_in,
  input  logic [$clog2(Ncbps)-1:0]          data_in_index,
  output logic                              ready_buffer,
  input  logic                              ready_in,
  output logic                              valid_out,
  output logic signed [W-1:0]               i_out,
  output logic signed [W-1:0]               q_out,
  output logic [$clog2(Ncbps/Ncpc)-1:0]     symbol_index,
  output logic                              last_symbol
);

  localparam int unsigned NSYM = Ncbps / Ncpc;
  localparam int unsigned IW   = $clog2(Ncbps);
  localparam int unsigned PW   = $clog2(NSYM);

  localparam logic signed [W-1:0] AMP_POS = W'(AMP);
  localparam logic signed [W-1:0] AMP_NEG = -AMP_POS;

  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [IW-1:0] wr_cnt;
  logic [PW-1:0] rd_ptr;
  logic          wr_fire;
  logic          rd_load;
  logic          rd_last;
  logic [1:0]    rd_bits;
  iq_sample_t    mapped;

  assign ready_buffer = !full[wr_bank];
  assign wr_fire      = valid_interleaver && ready_buffer && (32'(data_in_index) < Ncbps);
  assign rd_load      = (!valid_out || ready_in) && full[rd_bank];
  assign rd_last      = (rd_ptr == PW'(NSYM - 1));

  pingpong_bit_buffer #(
    .DEPTH (Ncbps),
    .AW    (IW),
    .PW    (PW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_bank (wr_bank),
    .wr_addr (data_in_index),
    .wr_data (data_in),
    .rd_bank (rd_bank),
    .rd_pair (rd_ptr),
    .rd_bits (rd_bits)
  );

  // Gray QPSK: I from the even bit, Q from the odd bit; 0 -> +AMP, 1 -> -AMP.
  always_comb begin
    mapped.i = rd_bits[0] ? AMP_NEG : AMP_POS;
    mapped.q = rd_bits[1] ? AMP_NEG : AMP_POS;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      full         <= '0;
      wr_cnt       <= '0;
      rd_ptr       <= '0;
      valid_out    <= 1'b0;
      i_out        <= '0;
      q_out        <= '0;
      symbol_index <= '0;
      last_symbol  <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == IW'(Ncbps - 1)) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      // The bank is released on load: the output register keeps the symbol,
      // so the writer may reuse the bank before the final handshake.
      if (rd_load) begin
        valid_out    <= 1'b1;
        i_out        <= mapped.i;
        q_out        <= mapped.q;
        symbol_index <= rd_ptr;
        last_symbol  <= rd_last;
        if (rd_last) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
          rd_ptr        <= '0;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_mapper_buffer.sv
module tb_qpsk_mapper_buffer;

  localparam int NB  = 192;
  localparam int NS  = 96;
  localparam int AMP = 23170;
  localparam logic [191:0] GOLD = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    int                 idx;
    bit                 last;
  } sym_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               valid_interleaver;
  logic               data_in;
  logic [7:0]         data_in_index;
  logic               ready_buffer;
  logic               ready_in;
  logic               valid_out;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic [6:0]         symbol_index;
  logic               last_symbol;

  always #5 clk = ~clk;

  qpsk_mapper_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .valid_interleaver (valid_interleaver),
    .data_in           (data_in),
    .data_in_index     (data_in_index),
    .ready_buffer      (ready_buffer),
    .ready_in          (ready_in),
    .valid_out         (valid_out),
    .i_out             (i_out),
    .q_out             (q_out),
    .symbol_index      (symbol_index),
    .last_symbol       (last_symbol)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic sym_t exp_sym(input logic [NB-1:0] blk, input int k);
    sym_t s;
    s.i    = blk[2*k]   ? -16'sd23170 : 16'sd23170;
    s.q    = blk[2*k+1] ? -16'sd23170 : 16'sd23170;
    s.idx  = k;
    s.last = (k == NS - 1);
    return s;
  endfunction

  // Cycle-level reference: completed blocks waiting to be drained, plus the
  // output register contents.
  logic [NB-1:0]      m_blk[$];
  logic [NB-1:0]      m_cur;
  int                 m_wcnt, m_rd, m_idx;
  bit                 m_valid, m_last, m_rdy, m_acc, m_ld;
  logic signed [15:0] m_i, m_q;
  bit                 started = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_blk.delete();
      m_wcnt = 0; m_rd = 0; m_valid = 0; m_i = 0; m_q = 0; m_idx = 0; m_last = 0;
    end else begin
      m_rdy = (m_blk.size() < 2);
      m_acc = valid_interleaver && m_rdy && (int'(data_in_index) < NB);
      m_ld  = (!m_valid || ready_in) && (m_blk.size() > 0);
      if (m_ld) begin
        m_i     = m_blk[0][2*m_rd]   ? -16'sd23170 : 16'sd23170;
        m_q     = m_blk[0][2*m_rd+1] ? -16'sd23170 : 16'sd23170;
        m_idx   = m_rd;
        m_last  = (m_rd == NS - 1);
        m_valid = 1;
        m_rd++;
        if (m_rd == NS) begin
          void'(m_blk.pop_front());
          m_rd = 0;
        end
      end else if (ready_in) begin
        m_valid = 0;
      end
      if (m_acc) begin
        m_cur[data_in_index] = data_in;
        m_wcnt++;
        if (m_wcnt == NB) begin
          m_blk.push_back(m_cur);
          m_wcnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("ready_buffer", ready_buffer, m_blk.size() < 2);
      check("valid_out", valid_out, m_valid);
      check("i_out", i_out, m_i);
      check("q_out", q_out, m_q);
      check("symbol_index", symbol_index, m_idx);
      check("last_symbol", last_symbol, m_last);
    end
  end

  // Delivered-symbol scoreboard, computed from the blocks as sent.
  sym_t               exp_q[$];
  sym_t               cap[4];
  sym_t               got, want;
  int                 hs_cnt = 0, last_cnt = 0, rb_low_cnt = 0;
  bit                 p_hold = 0;
  logic signed [15:0] p_i, p_q;
  logic [6:0]         p_idx;
  logic               p_last;

  always @(posedge clk) begin
    if (started && !reset) begin
      if (!ready_buffer) rb_low_cnt++;
      if (p_hold) begin
        check("hold_i", i_out, p_i);
        check("hold_q", q_out, p_q);
        check("hold_idx", symbol_index, p_idx);
        check("hold_last", last_symbol, p_last);
      end
      if (valid_out && ready_in) begin
        got.i = i_out; got.q = q_out; got.idx = int'(symbol_index); got.last = last_symbol;
        if (hs_cnt < 4) cap[hs_cnt] = got;
        hs_cnt++;
        if (last_symbol) last_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_symbol", 1, 0);
        end else begin
          want = exp_q.pop_front();
          check("sb_i", got.i, want.i);
          check("sb_q", got.q, want.q);
          check("sb_idx", got.idx, want.idx);
          check("sb_last", got.last, want.last);
        end
      end
    end
    p_hold = started && !reset && valid_out && !ready_in;
    p_i = i_out; p_q = q_out; p_idx = symbol_index; p_last = last_symbol;
  end

  // ready_in: 1 = always ready, 0 = stalled, 2 = random
  int rdy_mode = 1;
  initial begin
    ready_in = 1'b1;
    forever begin
      @(negedge clk);
      ready_in = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 0) ? 1'b0 : 1'($urandom_range(1));
    end
  end

  task automatic send_bit(input int idx, input logic b);
    int waitc = 0;
    @(negedge clk);
    valid_interleaver = 1'b1;
    data_in_index     = 8'(idx);
    data_in           = b;
    while (m_blk.size() >= 2) begin
      @(negedge clk);
      waitc++;
      if (waitc > 3000) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic push_block(input logic [NB-1:0] blk);
    for (int k = 0; k < NS; k++) exp_q.push_back(exp_sym(blk, k));
  endtask

  task automatic send_block(input logic [NB-1:0] blk, input bit rev);
    for (int n = 0; n < NB; n++) begin
      int idx = rev ? NB - 1 - n : n;
      send_bit(idx, blk[idx]);
    end
    push_block(blk);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_interleaver = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || valid_out) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("drain_timeout", c >= 3000, 0);
  endtask

  task automatic rand_block(output logic [NB-1:0] blk);
    for (int k = 0; k < NB; k++) blk[k] = 1'($urandom_range(1));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    valid_interleaver = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_valid", valid_out, 0);
    check("rst_ready", ready_buffer, 1);
    check("rst_i", i_out, 0);
    check("rst_q", q_out, 0);
    check("rst_idx", symbol_index, 0);
    check("rst_last", last_symbol, 0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  logic [NB-1:0] gblk, rblk;

  initial begin
    reset = 1'b1; valid_interleaver = 1'b0; data_in = 1'b0; data_in_index = '0;
    for (int k = 0; k < NB; k++) gblk[k] = GOLD[NB-1-k];
    @(posedge clk);
    started = 1;
    repeat (2) @(negedge clk);
    check("init_ready", ready_buffer, 1);
    check("init_valid", valid_out, 0);
    reset = 1'b0;

    // golden block, in order, with first-symbol latency
    hs_cnt = 0; last_cnt = 0;
    send_block(gblk, 0);
    @(negedge clk);
    valid_interleaver = 1'b0;
    check("lat_early", valid_out, 0);
    @(negedge clk);
    check("lat_valid", valid_out, 1);
    check("lat_idx", symbol_index, 0);
    drain();
    check("gold_count", hs_cnt, 96);
    check("gold_lasts", last_cnt, 1);
    check("s0_i", cap[0].i, 23170);  check("s0_q", cap[0].q, -23170);
    check("s1_i", cap[1].i, 23170);  check("s1_q", cap[1].q, 23170);
    check("s2_i", cap[2].i, -23170); check("s2_q", cap[2].q, 23170);
    check("s3_i", cap[3].i, -23170); check("s3_q", cap[3].q, -23170);

    // golden block, reverse index order
    hs_cnt = 0;
    send_block(gblk, 1);
    idle();
    drain();
    check("rev_count", hs_cnt, 96);
    check("rev_s1_q", cap[1].q, 23170);

    // ten back-to-back blocks
    hs_cnt = 0; last_cnt = 0; rb_low_cnt = 0;
    for (int b = 0; b < 10; b++) begin
      rand_block(rblk);
      send_block(rblk, b[0]);
    end
    idle();
    drain();
    check("b2b_count", hs_cnt, 960);
    check("b2b_lasts", last_cnt, 10);
    check("b2b_ready_low", rb_low_cnt, 0);

    // downstream stall for 400 cycles
    hs_cnt = 0; rb_low_cnt = 0;
    rdy_mode = 0;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          rand_block(rblk);
          send_block(rblk, 0);
        end
        idle();
      end
      begin
        repeat (400) @(negedge clk);
        rdy_mode = 1;
      end
    join
    drain();
    check("stall_count", hs_cnt, 288);
    check("stall_ready_dropped", rb_low_cnt > 0, 1);

    // random downstream readiness
    hs_cnt = 0;
    rdy_mode = 2;
    for (int b = 0; b < 2; b++) begin
      rand_block(rblk);
      send_block(rblk, 1);
    end
    idle();
    drain();
    rdy_mode = 1;
    check("rand_count", hs_cnt, 192);

    // out-of-range index is ignored
    hs_cnt = 0;
    rand_block(rblk);
    for (int n = 0; n < NB - 1; n++) send_bit(n, rblk[n]);
    send_bit(200, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    check("oob_no_block", valid_out, 0);
    send_bit(NB - 1, rblk[NB-1]);
    push_block(rblk);
    idle();
    drain();
    check("oob_count", hs_cnt, 96);

    // reset mid-block
    rand_block(rblk);
    for (int n = 0; n < 100; n++) send_bit(n, rblk[n]);
    apply_reset();
    hs_cnt = 0;
    rand_block(rblk);
    send_block(rblk, 0);
    idle();
    drain();
    check("rst_blk_count", hs_cnt, 96);

    // reset mid-drain
    hs_cnt = 0;
    rand_block(rblk);
    send_block(rblk, 0);
    idle();
    for (int c = 0; c < 500 && hs_cnt < 20; c++) @(negedge clk);
    check("drain_started", hs_cnt >= 20, 1);
    apply_reset();
    hs_cnt = 0;
    rand_block(rblk);
    send_block(rblk, 1);
    idle();
    drain();
    check("rst_drain_count", hs_cnt, 96);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
